// File: rtl/outmem_arb_if.sv
// Port-A bundle for outmem_arb: requester handshake, clear control and memory port-A command.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface outmem_arb_if #(
  parameter int data_width = 64,
  parameter int addr_width = 5
);
  logic [3:0]              req;
  logic [3:0]              we;
  logic [4*addr_width-1:0] addr;
  logic [4*data_width-1:0] wdata;
  logic [3:0]              ack;
  logic [3:0]              rvalid;
  logic [data_width-1:0]   rdata;
  logic                    clr;
  logic [data_width-1:0]   clr_data;
  logic                    busy;
  logic                    clr_done;
  logic                    mem_en;
  logic                    mem_we;
  logic [addr_width-1:0]   mem_addr;
  logic [data_width-1:0]   mem_wdata;
  logic [data_width-1:0]   mem_rdata;

  modport master (
    output req, we, addr, wdata, clr, clr_data, mem_rdata,
    input  ack, rvalid, rdata, busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, wdata, clr, clr_data, mem_rdata,
    output ack, rvalid, rdata, busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/outmem_arb.sv
// Port-A controller for the output memory: round-robin arbiter over four requesters
// with a registered handshake, plus a sequencer that fills every word with one value.
//
// state | meaning
// ARB   | grant one eligible requester per cycle, or start a clear
// CLEAR | write the captured fill value to one address per cycle
module outmem_arb #(
  parameter int data_width = 64,
  parameter int addr_width = 5
) (
  input logic         clk,
  input logic         rst,
  outmem_arb_if.slave bus
);
  typedef enum logic {ARB, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic [3:0]            mask_q, mask_d;
  logic [data_width-1:0] clr_val_q, clr_val_d;
  logic [3:0]            ack_q, ack_d;
  logic [3:0]            rvalid_q, rvalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] maddr_q, maddr_d;
  logic [data_width-1:0] wdata_q, wdata_d;

  logic [3:0] eligible;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    clr_val_d = clr_val_q;
    ack_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    en_d      = 1'b0;
    we_d      = 1'b0;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    // read data returns the cycle after the command, writes never flag it
    rvalid_d  = we_q ? 4'b0000 : ack_q;

    eligible = bus.req & ~mask_q;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state_q)
      ARB: begin
        if (bus.clr) begin
          state_d   = CLEAR;
          clr_val_d = bus.clr_data;
          en_d      = 1'b1;
          we_d      = 1'b1;
          maddr_d   = '0;
          wdata_d   = bus.clr_data;
          busy_d    = 1'b1;
          cnt_d     = addr_width'(1);
          mask_d    = '0;
        end else if (found) begin
          en_d    = 1'b1;
          we_d    = bus.we[win];
          maddr_d = bus.addr[int'(win)*addr_width +: addr_width];
          wdata_d = bus.wdata[int'(win)*data_width +: data_width];
          ack_d   = 4'b0001 << win;
          mask_d  = 4'b0001 << win;
          ptr_d   = win + 2'd1;
        end else begin
          mask_d = '0;
        end
      end
      CLEAR: begin
        // counter wraps to zero once the last address has been issued
        if (cnt_q == '0) begin
          state_d = ARB;
          done_d  = 1'b1;
        end else begin
          en_d    = 1'b1;
          we_d    = 1'b1;
          maddr_d = cnt_q;
          wdata_d = clr_val_q;
          busy_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      clr_val_q <= '0;
      ack_q     <= '0;
      rvalid_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      clr_val_q <= clr_val_d;
      ack_q     <= ack_d;
      rvalid_q  <= rvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      en_q      <= en_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.busy      = busy_q;
  assign bus.clr_done  = done_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_outmem_arb.sv
// Directed bench for outmem_arb: vector table for arbitration, hand sequences for
// single read, clear, reset mid-clear and write-then-read; port A memory is modelled here.
module tb_outmem_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  logic [63:0] mem [32];
  int n_cmp = 0;
  int n_err = 0;

  outmem_arb_if #(.data_width(64), .addr_width(5)) bus ();
  outmem_arb #(.data_width(64), .addr_width(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // read-first single-port model; mem[] is also what port B would see
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 5) ? 64'hA5 : 64'hC000 + 64'(i);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  ack;
    logic        en;
    logic        mwe;
    logic [4:0]  maddr;
    logic [3:0]  rvalid;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs [15];
  int   done_seen;

  initial begin
    vecs[0]  = '{4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 5'd1, 4'h0, 64'h0};
    vecs[1]  = '{4'hF, 4'h0, 4'h2, 1'b1, 1'b0, 5'd2, 4'h1, 64'hC001};
    vecs[2]  = '{4'hF, 4'h0, 4'h4, 1'b1, 1'b0, 5'd3, 4'h2, 64'hC002};
    vecs[3]  = '{4'hF, 4'h0, 4'h8, 1'b1, 1'b0, 5'd4, 4'h4, 64'hC003};
    vecs[4]  = '{4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 5'd1, 4'h8, 64'hC004};
    vecs[5]  = '{4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h1, 64'hC001};
    vecs[6]  = '{4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 5'd1, 4'h0, 64'h0};
    vecs[7]  = '{4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h1, 64'hC001};
    vecs[8]  = '{4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 5'd1, 4'h0, 64'h0};
    vecs[9]  = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h1, 64'hC001};
    vecs[10] = '{4'hA, 4'hA, 4'h2, 1'b1, 1'b1, 5'd2, 4'h0, 64'h0};
    vecs[11] = '{4'hA, 4'hA, 4'h8, 1'b1, 1'b1, 5'd4, 4'h0, 64'h0};
    vecs[12] = '{4'hA, 4'hA, 4'h2, 1'b1, 1'b1, 5'd2, 4'h0, 64'h0};
    vecs[13] = '{4'h4, 4'h0, 4'h4, 1'b1, 1'b0, 5'd3, 4'h0, 64'h0};
    vecs[14] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h4, 64'hC003};

    bus.req      = '0;
    bus.we       = '0;
    bus.addr     = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.wdata    = {64'h103, 64'h102, 64'h101, 64'h100};
    bus.clr      = 1'b0;
    bus.clr_data = '0;

    step();
    step();
    mem_init = 1'b0;
    chk("rst_ack", bus.ack, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_clr_done", bus.clr_done, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;

    // arbitration table: round robin, same-requester mask, mixed writes
    for (int i = 0; i < 15; i++) begin
      bus.req = vecs[i].req;
      bus.we  = vecs[i].we;
      step();
      chk($sformatf("vec%0d_ack", i), bus.ack, vecs[i].ack);
      chk($sformatf("vec%0d_en", i), bus.mem_en, vecs[i].en);
      chk($sformatf("vec%0d_rvalid", i), bus.rvalid, vecs[i].rvalid);
      if (vecs[i].en) begin
        chk($sformatf("vec%0d_we", i), bus.mem_we, vecs[i].mwe);
        chk($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].maddr);
      end
      if (vecs[i].rvalid != 0) chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].rdata);
    end

    // single read of requester 2 at address 5
    bus.addr[10 +: 5] = 5'd5;
    bus.req = 4'b0100;
    bus.we  = 4'b0000;
    step();
    chk("rd_ack", bus.ack, 4'b0100);
    chk("rd_addr", bus.mem_addr, 5);
    chk("rd_we", bus.mem_we, 0);
    bus.req = 4'b0000;
    step();
    chk("rd_rvalid", bus.rvalid, 4'b0100);
    chk("rd_rdata", bus.rdata, 64'hA5);
    chk("rd_ack_gone", bus.ack, 0);
    step();
    chk("rd_idle_ack", bus.ack, 0);
    chk("rd_idle_rvalid", bus.rvalid, 0);

    // clear beats a simultaneous request
    bus.clr      = 1'b1;
    bus.clr_data = 64'hDEAD_BEEF;
    bus.req      = 4'b0010;
    step();
    bus.clr = 1'b0;
    chk("clr0_busy", bus.busy, 1);
    chk("clr0_en", bus.mem_en, 1);
    chk("clr0_we", bus.mem_we, 1);
    chk("clr0_addr", bus.mem_addr, 0);
    chk("clr0_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
    chk("clr0_ack", bus.ack, 0);
    for (int i = 1; i < 32; i++) begin
      step();
      chk($sformatf("clr%0d_addr", i), bus.mem_addr, 64'(i));
      chk($sformatf("clr%0d_busy", i), bus.busy & bus.mem_en & bus.mem_we, 1);
      chk($sformatf("clr%0d_ack", i), bus.ack, 0);
    end
    step();
    chk("clr_exit_busy", bus.busy, 0);
    chk("clr_exit_done", bus.clr_done, 1);
    chk("clr_exit_en", bus.mem_en, 0);
    chk("clr_exit_ack", bus.ack, 0);
    step();
    chk("clr_first_ack", bus.ack, 4'b0010);
    chk("clr_done_pulse", bus.clr_done, 0);
    bus.req = 4'b0000;
    step();
    for (int a = 0; a < 32; a++) chk($sformatf("clr_mem%0d", a), mem[a], 64'hDEAD_BEEF);

    // reset during a clear: addresses 0..9 written, 10..31 untouched
    bus.clr      = 1'b1;
    bus.clr_data = 64'h5555;
    step();
    bus.clr = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("rmc_addr9", bus.mem_addr, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmc_ack", bus.ack, 0);
    chk("rmc_busy", bus.busy, 0);
    chk("rmc_en", bus.mem_en, 0);
    chk("rmc_we", bus.mem_we, 0);
    chk("rmc_addr", bus.mem_addr, 0);
    chk("rmc_done", bus.clr_done, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.clr_done || bus.busy) done_seen++;
    end
    chk("rmc_no_done", done_seen, 0);
    for (int a = 0; a < 32; a++)
      chk($sformatf("rmc_mem%0d", a), mem[a], (a < 10) ? 64'h5555 : 64'hDEAD_BEEF);

    // requester 3 writes then reads address 7
    bus.addr[15 +: 5]  = 5'd7;
    bus.wdata[192 +: 64] = 64'h1234;
    bus.req = 4'b1000;
    bus.we  = 4'b1000;
    step();
    chk("wr_ack", bus.ack, 4'b1000);
    chk("wr_we", bus.mem_we, 1);
    chk("wr_addr", bus.mem_addr, 7);
    chk("wr_wdata", bus.mem_wdata, 64'h1234);
    bus.we = 4'b0000;
    step();
    chk("wr_masked_ack", bus.ack, 0);
    chk("wr_no_rvalid", bus.rvalid, 0);
    step();
    chk("rb_ack", bus.ack, 4'b1000);
    chk("rb_we", bus.mem_we, 0);
    chk("rb_addr", bus.mem_addr, 7);
    bus.req = 4'b0000;
    step();
    chk("rb_rvalid", bus.rvalid, 4'b1000);
    chk("rb_rdata", bus.rdata, 64'h1234);
    step();
    chk("rb_rvalid_gone", bus.rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
